// File: rtl/pipeline_pkg.sv
// Shared pipeline constants, fetch-stage state encoding and select codes.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pipeline_pkg;

    // Bubble instruction word: sll $0,$0,0
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // FETCH: request outstanding; HOLD: word buffered while decode stalls;
    // DROP: the outstanding request belongs to a squashed path.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } fetch_state_t;

    // Source of the next PC value
    typedef enum logic [1:0] {
        NPC_KEEP     = 2'd0,
        NPC_SEQ      = 2'd1,
        NPC_REDIRECT = 2'd2,
        NPC_PENDING  = 2'd3
    } npc_sel_t;

    // What the FE/DEC output registers load this cycle
    typedef enum logic [1:0] {
        OUT_KEEP   = 2'd0,
        OUT_BUBBLE = 2'd1,
        OUT_MEM    = 2'd2,
        OUT_BUF    = 2'd3
    } out_sel_t;

    // Instruction addresses are word aligned; low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection: sequential, branch/jump redirect, or pending target.
// Latency: purely combinational.
// Backpressure: none; the caller chooses NPC_KEEP to hold the PC.
module fetch_next_pc
    import pipeline_pkg::*;
(
    input  npc_sel_t    i_sel,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pending_pc,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_jump,
    input  logic [31:0] i_jump_target,
    output logic [31:0] o_pc_plus4,
    output logic        o_redirect,
    output logic [31:0] o_redirect_target,
    output logic [31:0] o_next_pc
);

    // PC+4 wraps naturally at 2^32
    assign o_pc_plus4 = i_pc + 32'd4;

    // A taken branch beats a simultaneous jump
    assign o_redirect        = i_branch_taken | i_jump;
    assign o_redirect_target = word_align(i_branch_taken ? i_branch_target : i_jump_target);

    // Mux the next PC from the requested source
    always_comb begin
        o_next_pc = i_pc;
        case (i_sel)
            NPC_KEEP:     o_next_pc = i_pc;
            NPC_SEQ:      o_next_pc = o_pc_plus4;
            NPC_REDIRECT: o_next_pc = o_redirect_target;
            NPC_PENDING:  o_next_pc = i_pending_pc;
            default:      o_next_pc = i_pc;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch stage: PC register, imem request, FE/DEC output register.
// Latency: instruction appears on the outputs one cycle after its ack.
// Backpressure: StallIn freezes outputs and PC; an acked word is parked in HOLD.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = pipeline_pkg::DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        StallIn,
    input  logic        BranchTakenIn,
    input  logic [31:0] BranchTargetIn,
    input  logic        JumpIn,
    input  logic [31:0] JumpTargetIn,
    output logic        IMemReqOut,
    output logic [31:0] IMemAddrOut,
    input  logic        IMemAckIn,
    input  logic [31:0] IMemDataIn,
    output logic [31:0] InstructionOut,
    output logic [31:0] PC4Out,
    output logic        ValidOut
);

    import pipeline_pkg::*;

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_pending_pc;
    logic [31:0]  r_hold_buf;
    logic [31:0]  r_instr;
    logic [31:0]  r_pc4;
    logic         r_valid;

    npc_sel_t     w_npc_sel;
    out_sel_t     w_out_sel;
    logic         w_pending_ld;
    logic         w_buf_ld;
    logic [31:0]  w_pc_plus4;
    logic         w_redirect;
    logic [31:0]  w_redirect_target;
    logic [31:0]  w_next_pc;

    fetch_next_pc u_next_pc (
        .i_sel             (w_npc_sel),
        .i_pc              (r_pc),
        .i_pending_pc      (r_pending_pc),
        .i_branch_taken    (BranchTakenIn),
        .i_branch_target   (BranchTargetIn),
        .i_jump            (JumpIn),
        .i_jump_target     (JumpTargetIn),
        .o_pc_plus4        (w_pc_plus4),
        .o_redirect        (w_redirect),
        .o_redirect_target (w_redirect_target),
        .o_next_pc         (w_next_pc)
    );

    // The address is the PC itself, so it is stable until the ack arrives
    assign IMemReqOut     = (r_state != ST_HOLD);
    assign IMemAddrOut    = r_pc;
    assign InstructionOut = r_instr;
    assign PC4Out         = r_pc4;
    assign ValidOut       = r_valid;

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; redirect outranks stall everywhere
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FETCH: begin
                if (w_redirect) begin
                    w_state_nxt = IMemAckIn ? ST_FETCH : ST_DROP;
                end else if (StallIn && IMemAckIn) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_HOLD: begin
                if (w_redirect || !StallIn) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_DROP: begin
                w_state_nxt = IMemAckIn ? ST_FETCH : ST_DROP;
            end
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    // Output/datapath decode: PC source, output register source, buffer loads
    always_comb begin
        w_npc_sel    = NPC_KEEP;
        w_out_sel    = OUT_KEEP;
        w_pending_ld = 1'b0;
        w_buf_ld     = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (w_redirect) begin
                    // Data for the old path is discarded; wait it out if not yet here
                    w_out_sel = OUT_BUBBLE;
                    if (IMemAckIn) begin
                        w_npc_sel = NPC_REDIRECT;
                    end else begin
                        w_pending_ld = 1'b1;
                    end
                end else if (StallIn) begin
                    w_buf_ld = IMemAckIn;
                end else if (IMemAckIn) begin
                    w_out_sel = OUT_MEM;
                    w_npc_sel = NPC_SEQ;
                end else begin
                    w_out_sel = OUT_BUBBLE;
                end
            end
            ST_HOLD: begin
                if (w_redirect) begin
                    w_out_sel = OUT_BUBBLE;
                    w_npc_sel = NPC_REDIRECT;
                end else if (!StallIn) begin
                    w_out_sel = OUT_BUF;
                    w_npc_sel = NPC_SEQ;
                end
            end
            ST_DROP: begin
                if (w_redirect) begin
                    // Newest redirect wins over the stored one
                    w_out_sel = OUT_BUBBLE;
                    if (IMemAckIn) begin
                        w_npc_sel = NPC_REDIRECT;
                    end else begin
                        w_pending_ld = 1'b1;
                    end
                end else begin
                    if (IMemAckIn) begin
                        w_npc_sel = NPC_PENDING;
                    end
                    if (!StallIn) begin
                        w_out_sel = OUT_BUBBLE;
                    end
                end
            end
            default: begin
                w_out_sel = OUT_BUBBLE;
            end
        endcase
    end

    // PC, pending target, hold buffer and FE/DEC output registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pc         <= RESET_PC;
            r_pending_pc <= 32'h0000_0000;
            r_hold_buf   <= 32'h0000_0000;
            r_instr      <= NOP_INSTR;
            r_pc4        <= 32'h0000_0000;
            r_valid      <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            if (w_pending_ld) begin
                r_pending_pc <= w_redirect_target;
            end
            if (w_buf_ld) begin
                r_hold_buf <= IMemDataIn;
            end
            case (w_out_sel)
                OUT_MEM: begin
                    r_instr <= IMemDataIn;
                    r_pc4   <= w_pc_plus4;
                    r_valid <= 1'b1;
                end
                OUT_BUF: begin
                    r_instr <= r_hold_buf;
                    r_pc4   <= w_pc_plus4;
                    r_valid <= 1'b1;
                end
                OUT_BUBBLE: begin
                    r_instr <= NOP_INSTR;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_instr <= r_instr;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: vector table plus an async-reset sequence.
// Latency: checks registered outputs #1 after each rising edge.
// Backpressure: memory ack is driven per vector to model stalls and delays.
module tb_pc_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        StallIn;
    logic        BranchTakenIn;
    logic [31:0] BranchTargetIn;
    logic        JumpIn;
    logic [31:0] JumpTargetIn;
    logic        IMemReqOut;
    logic [31:0] IMemAddrOut;
    logic        IMemAckIn;
    logic [31:0] IMemDataIn;
    logic [31:0] InstructionOut;
    logic [31:0] PC4Out;
    logic        ValidOut;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    // Memory image: the word at address a is ~a
    assign IMemDataIn = ~IMemAddrOut;

    pc_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .StallIn        (StallIn),
        .BranchTakenIn  (BranchTakenIn),
        .BranchTargetIn (BranchTargetIn),
        .JumpIn         (JumpIn),
        .JumpTargetIn   (JumpTargetIn),
        .IMemReqOut     (IMemReqOut),
        .IMemAddrOut    (IMemAddrOut),
        .IMemAckIn      (IMemAckIn),
        .IMemDataIn     (IMemDataIn),
        .InstructionOut (InstructionOut),
        .PC4Out         (PC4Out),
        .ValidOut       (ValidOut)
    );

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jmp;
        logic [31:0] jt;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc4;
        logic        exp_valid;
    } vec_t;

    localparam int NV = 35;
    localparam logic [31:0] NOP = 32'h0000_0000;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic stall, input logic br, input logic [31:0] bt,
                                input logic jmp, input logic [31:0] jt, input logic ack,
                                input logic req, input logic [31:0] addr,
                                input logic [31:0] instr, input logic [31:0] pc4,
                                input logic valid);
        vec_t v;
        v.stall = stall; v.br = br; v.bt = bt; v.jmp = jmp; v.jt = jt; v.ack = ack;
        v.exp_req = req; v.exp_addr = addr; v.exp_instr = instr;
        v.exp_pc4 = pc4; v.exp_valid = valid;
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //            stall br bt            jmp jt             ack  req addr           instr           pc4           valid
        // straight-line fetch, ack every cycle
        vecs[0]  = mk(0, 0, 32'h0,   0, 32'h0,          1,   1, 32'h0,          ~32'h0,         32'h4,        1);
        vecs[1]  = mk(0, 0, 32'h0,   0, 32'h0,          1,   1, 32'h4,          ~32'h4,         32'h8,        1);
        vecs[2]  = mk(0, 0, 32'h0,   0, 32'h0,          1,   1, 32'h8,          ~32'h8,         32'hC,        1);
        vecs[3]  = mk(0, 0, 32'h0,   0, 32'h0,          1,   1, 32'hC,          ~32'hC,         32'h10,       1);
        // jump back to 4 with ack: bubble, then refetch
        vecs[4]  = mk(0, 0, 32'h0,   1, 32'h4,          1,   1, 32'h10,         NOP,            32'h10,       0);
        vecs[5]  = mk(0, 0, 32'h0,   0, 32'h0,          1,   1, 32'h4,          ~32'h4,         32'h8,        1);
        // stall 3 cycles with ack at PC 8
        vecs[6]  = mk(1, 0, 32'h0,   0, 32'h0,          1,   1, 32'h8,          ~32'h4,         32'h8,        1);
        vecs[7]  = mk(1, 0, 32'h0,   0, 32'h0,          0,   0, 32'h8,          ~32'h4,         32'h8,        1);
        vecs[8]  = mk(1, 0, 32'h0,   0, 32'h0,          0,   0, 32'h8,          ~32'h4,         32'h8,        1);
        vecs[9]  = mk(0, 0, 32'h0,   0, 32'h0,          0,   0, 32'h8,          ~32'h8,         32'hC,        1);
        vecs[10] = mk(0, 0, 32'h0,   0, 32'h0,          1,   1, 32'hC,          ~32'hC,         32'h10,       1);
        // taken branch to 0x40 with ack
        vecs[11] = mk(0, 1, 32'h40,  0, 32'h0,          1,   1, 32'h10,         NOP,            32'h10,       0);
        vecs[12] = mk(0, 0, 32'h0,   0, 32'h0,          1,   1, 32'h40,         ~32'h40,        32'h44,       1);
        // jump to 0x80 while ack is 2 cycles late
        vecs[13] = mk(0, 0, 32'h0,   1, 32'h80,         0,   1, 32'h44,         NOP,            32'h44,       0);
        vecs[14] = mk(0, 0, 32'h0,   0, 32'h0,          0,   1, 32'h44,         NOP,            32'h44,       0);
        vecs[15] = mk(0, 0, 32'h0,   0, 32'h0,          1,   1, 32'h44,         NOP,            32'h44,       0);
        vecs[16] = mk(0, 0, 32'h0,   0, 32'h0,          1,   1, 32'h80,         ~32'h80,        32'h84,       1);
        // branch + jump together during stall: branch wins
        vecs[17] = mk(1, 1, 32'h40,  1, 32'h100,        1,   1, 32'h84,         NOP,            32'h84,       0);
        vecs[18] = mk(0, 0, 32'h0,   0, 32'h0,          1,   1, 32'h40,         ~32'h40,        32'h44,       1);
        // unaligned target is word aligned
        vecs[19] = mk(0, 0, 32'h0,   1, 32'h8B,         1,   1, 32'h44,         NOP,            32'h44,       0);
        vecs[20] = mk(0, 0, 32'h0,   0, 32'h0,          1,   1, 32'h88,         ~32'h88,        32'h8C,       1);
        // PC+4 wraps at the top of memory
        vecs[21] = mk(0, 0, 32'h0,   1, 32'hFFFF_FFFC,  1,   1, 32'h8C,         NOP,            32'h8C,       0);
        vecs[22] = mk(0, 0, 32'h0,   0, 32'h0,          1,   1, 32'hFFFF_FFFC,  32'h3,          32'h0,        1);
        vecs[23] = mk(0, 0, 32'h0,   0, 32'h0,          1,   1, 32'h0,          ~32'h0,         32'h4,        1);
        // no ack, no stall: bubble; no ack with stall: hold
        vecs[24] = mk(0, 0, 32'h0,   0, 32'h0,          0,   1, 32'h4,          NOP,            32'h4,        0);
        vecs[25] = mk(0, 0, 32'h0,   0, 32'h0,          1,   1, 32'h4,          ~32'h4,         32'h8,        1);
        vecs[26] = mk(1, 0, 32'h0,   0, 32'h0,          0,   1, 32'h8,          ~32'h4,         32'h8,        1);
        vecs[27] = mk(0, 0, 32'h0,   0, 32'h0,          1,   1, 32'h8,          ~32'h8,         32'hC,        1);
        // redirect out of HOLD discards the buffered word
        vecs[28] = mk(1, 0, 32'h0,   0, 32'h0,          1,   1, 32'hC,          ~32'h8,         32'hC,        1);
        vecs[29] = mk(0, 1, 32'h20,  0, 32'h0,          0,   0, 32'hC,          NOP,            32'hC,        0);
        vecs[30] = mk(0, 0, 32'h0,   0, 32'h0,          1,   1, 32'h20,         ~32'h20,        32'h24,       1);
        // second redirect in DROP overwrites the pending target
        vecs[31] = mk(0, 0, 32'h0,   1, 32'h200,        0,   1, 32'h24,         NOP,            32'h24,       0);
        vecs[32] = mk(0, 1, 32'h300, 0, 32'h0,          0,   1, 32'h24,         NOP,            32'h24,       0);
        vecs[33] = mk(0, 0, 32'h0,   0, 32'h0,          1,   1, 32'h24,         NOP,            32'h24,       0);
        vecs[34] = mk(0, 0, 32'h0,   0, 32'h0,          1,   1, 32'h300,        ~32'h300,       32'h304,      1);

        Rst_n = 1'b0;
        StallIn = 1'b0; BranchTakenIn = 1'b0; BranchTargetIn = 32'h0;
        JumpIn = 1'b0; JumpTargetIn = 32'h0; IMemAckIn = 1'b0;

        // Reset state
        repeat (2) @(posedge Clk);
        #1;
        check32("reset instr", InstructionOut, NOP);
        check32("reset pc4",   PC4Out, 32'h0);
        check32("reset valid", {31'h0, ValidOut}, 32'h0);
        check32("reset req",   {31'h0, IMemReqOut}, 32'h1);
        check32("reset addr",  IMemAddrOut, 32'h0);
        Rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            StallIn        = vecs[i].stall;
            BranchTakenIn  = vecs[i].br;
            BranchTargetIn = vecs[i].bt;
            JumpIn         = vecs[i].jmp;
            JumpTargetIn   = vecs[i].jt;
            IMemAckIn      = vecs[i].ack;
            #1;
            check32($sformatf("v%0d req", i),  {31'h0, IMemReqOut}, {31'h0, vecs[i].exp_req});
            check32($sformatf("v%0d addr", i), IMemAddrOut, vecs[i].exp_addr);
            @(posedge Clk);
            #1;
            check32($sformatf("v%0d instr", i), InstructionOut, vecs[i].exp_instr);
            check32($sformatf("v%0d pc4", i),   PC4Out, vecs[i].exp_pc4);
            check32($sformatf("v%0d valid", i), {31'h0, ValidOut}, {31'h0, vecs[i].exp_valid});
        end

        // Enter HOLD at PC 0x304, then pulse reset mid-cycle
        StallIn = 1'b1; BranchTakenIn = 1'b0; JumpIn = 1'b0; IMemAckIn = 1'b1;
        @(posedge Clk);
        #1;
        IMemAckIn = 1'b0;
        check32("hold req",   {31'h0, IMemReqOut}, 32'h0);
        check32("hold instr", InstructionOut, ~32'h300);
        check32("hold pc4",   PC4Out, 32'h304);
        #2;
        Rst_n = 1'b0;
        #1;
        check32("arst instr", InstructionOut, NOP);
        check32("arst pc4",   PC4Out, 32'h0);
        check32("arst valid", {31'h0, ValidOut}, 32'h0);
        check32("arst addr",  IMemAddrOut, 32'h0);
        check32("arst req",   {31'h0, IMemReqOut}, 32'h1);
        @(negedge Clk);
        Rst_n = 1'b1;
        StallIn = 1'b0;
        IMemAckIn = 1'b1;
        #1;
        check32("post-reset req",  {31'h0, IMemReqOut}, 32'h1);
        check32("post-reset addr", IMemAddrOut, 32'h0);
        @(posedge Clk);
        #1;
        check32("post-reset instr", InstructionOut, ~32'h0);
        check32("post-reset pc4",   PC4Out, 32'h4);
        check32("post-reset valid", {31'h0, ValidOut}, 32'h1);
        check32("post-reset next",  IMemAddrOut, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
